if_fetch_unit: RTL and testbench

Instruction fetch stage for the rv32 pipeline. Generates sequential PCs, issues word requests to instruction memory, buffers returned instruction words with their PCs, and presents them in program order to the decode stage over a valid/ready handshake. Redirects from branch/jump resolution flush queued and in-flight fetches. The decode stage consumes `id_instruction`.

---
 rtl/rv32_pipe_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 tb/tb_if_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared rv32 pipeline types and constants: NOP encoding, default reset vector
// and the fetch buffer entry.
package rv32_pipe_pkg;

    localparam logic [31:0] RV32_NOP          = 32'h0000_0013;
    localparam logic [31:0] RV32_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is the
// registered oldest entry and is only meaningful while not empty.
module fetch_fifo
    import rv32_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/if_fetch_unit.sv
// rv32 instruction fetch: sequential PC generation, in-order response buffering,
// redirect flush. Define IFETCH_PERF_EN to add perf_fetch_cnt / perf_drop_cnt.
module if_fetch_unit
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV32_RESET_VECTOR,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_data;
    logic          req_fire, pop, push, rsp_drop;
    logic [CW-1:0] rsp_dec;
    logic [31:0]   target;

    always_comb begin
        target         = word_align(redirect_pc);
        // Outstanding requests plus buffered words never exceed DEPTH, so every
        // response has a slot waiting; rst_n gates the request during reset.
        imem_req_valid = rst_n && !redirect_valid && ((inflight_q + fifo_count) < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        id_valid       = !fifo_empty && !redirect_valid;
        pop            = id_valid && id_ready;
        rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
        push           = imem_rsp_valid && !rsp_drop;
        push_data      = '{pc: rsp_pc_q, instr: imem_rsp_data};
        rsp_dec        = imem_rsp_valid ? ONE : '0;

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + (req_fire ? ONE : '0) - rsp_dec;
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            drop_cnt_d = inflight_q + drop_cnt_q - rsp_dec;
        end else begin
            if (req_fire)                             fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)                                 rsp_pc_d   = rsp_pc_q + 32'd4;
            if (imem_rsp_valid && drop_cnt_q != '0)   drop_cnt_d = drop_cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= word_align(RESET_PC);
            rsp_pc_q   <= word_align(RESET_PC);
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // An empty buffer shows a NOP at the next response PC (RESET_PC out of reset).
    assign imem_req_addr  = fetch_pc_q;
    assign id_instruction = fifo_empty ? RV32_NOP : fifo_head.instr;
    assign id_pc          = fifo_empty ? rsp_pc_q : fifo_head.pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'b0, pop};
        perf_drop_d  = perf_drop_q + {31'b0, rsp_drop}
                     + (redirect_valid ? 32'(fifo_count) : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a memory model answers requests with ~addr,
// expected {pc, ~pc} words are queued by the stimulus and checked by a monitor.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instruction, id_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Memory model, accepted-request log, scoreboard queue, pop statistics.
    int          mem_lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] exp_q[$];
    int          n_pop = 0;
    int          first_pop_cyc = -1;
    int          last_pop_cyc = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + mem_lat);
                acc_addr.push_back(imem_req_addr);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Monitor: decode handshakes against the scoreboard, head stability, redirect gating.
    initial begin
        logic        hold_pend;
        logic [31:0] hold_pc, hold_ins, e;
        hold_pend = 1'b0;
        hold_pc   = '0;
        hold_ins  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (redirect_valid) check("id_valid_on_redirect", {31'b0, id_valid}, 32'd0);
                if (hold_pend && id_valid) begin
                    check("head_hold_pc", id_pc, hold_pc);
                    check("head_hold_instr", id_instruction, hold_ins);
                end
                hold_pend = id_valid && !id_ready;
                hold_pc   = id_pc;
                hold_ins  = id_instruction;
                if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pop_pc", id_pc, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("id_pc", id_pc, e);
                        check("id_instruction", id_instruction, ~e);
                    end
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    n_pop++;
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        logic [31:0] pc;
        pc = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    // Asserts reset mid-cycle, checks outputs take reset values at once,
    // then releases with the given memory latency and ready levels.
    task automatic do_reset(input int lat, input logic rr, input logic ir);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        id_ready = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_id_instruction", id_instruction, 32'h0000_0013);
        check("rst_id_pc", id_pc, 32'h0000_0000);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
        pend_addr.delete();
        pend_due.delete();
        acc_addr.delete();
        acc_cyc.delete();
        exp_q.delete();
        n_pop = 0;
        first_pop_cyc = -1;
        last_pop_cyc = -1;
        mem_lat = lat;
        tick();
        tick();
        imem_req_ready = rr;
        id_ready = ir;
        rst_n = 1'b1;
    endtask

    initial begin
        int rcyc;

        // Streaming at latency 1: one request and one decode per cycle.
        do_reset(1, 1'b1, 1'b1);
        push_seq(32'h0, 40);
        repeat (15) tick();
        imem_req_ready = 1'b0;
        repeat (8) tick();
        check("s1_acc_count", acc_addr.size(), 32'd15);
        check("s1_addr0", acc_addr[0], 32'h0);
        check("s1_addr1", acc_addr[1], 32'h4);
        check("s1_addr2", acc_addr[2], 32'h8);
        check("s1_first_valid_latency", first_pop_cyc - acc_cyc[0], 32'd2);
        check("s1_pops_eq_accepts", n_pop, acc_addr.size());
        check("s1_back_to_back", last_pop_cyc - first_pop_cyc, n_pop - 1);

        // Decode stalled: buffer fills with exactly DEPTH requests, then resumes.
        do_reset(1, 1'b1, 1'b0);
        push_seq(32'h0, 40);
        repeat (20) tick();
        check("s2_acc_count_stalled", acc_addr.size(), 32'd4);
        check("s2_req_valid_stalled", {31'b0, imem_req_valid}, 32'd0);
        check("s2_id_valid_stalled", {31'b0, id_valid}, 32'd1);
        check("s2_head_pc_stalled", id_pc, 32'h0);
        id_ready = 1'b1;
        repeat (12) tick();
        imem_req_ready = 1'b0;
        repeat (10) tick();
        check("s2_addr4", acc_addr[4], 32'h10);
        check("s2_pops_eq_accepts", n_pop, acc_addr.size());

        // Latency 3: one buffered entry and two in flight when redirected to 0x100.
        do_reset(3, 1'b1, 1'b0);
        push_seq(32'h100, 30);
        tick(); imem_req_ready = 1'b0;
        tick();
        tick(); imem_req_ready = 1'b1;
        tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; rcyc = cyc;
        tick(); redirect_valid = 1'b0; id_ready = 1'b1;
        repeat (15) tick();
        imem_req_ready = 1'b0;
        repeat (12) tick();
        check("s3_addr_pre2", acc_addr[2], 32'h8);
        check("s3_addr_redirect", acc_addr[3], 32'h100);
        check("s3_redirect_req_cycle", acc_cyc[3], rcyc + 1);
        check("s3_pops_eq_live", n_pop, acc_addr.size() - 3);
`ifdef IFETCH_PERF_EN
        check("s3_perf_drop", perf_drop_cnt, 32'd3);
        check("s3_perf_fetch", perf_fetch_cnt, n_pop);
`endif

        // Redirect coinciding with a response while decode is ready.
        do_reset(1, 1'b1, 1'b1);
        exp_q.push_back(32'h0);
        push_seq(32'h200, 30);
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; rcyc = cyc;
        #1;
        check("s4_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        tick(); redirect_valid = 1'b0;
        repeat (10) tick();
        imem_req_ready = 1'b0;
        repeat (8) tick();
        check("s4_addr_redirect", acc_addr[3], 32'h200);
        check("s4_redirect_req_cycle", acc_cyc[3], rcyc + 1);
        check("s4_pops_eq_live", n_pop, acc_addr.size() - 2);
`ifdef IFETCH_PERF_EN
        check("s4_perf_drop", perf_drop_cnt, 32'd2);
`endif

        // Misaligned redirect near the top of the address space wraps to 0.
        do_reset(1, 1'b1, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        push_seq(32'h0, 20);
        tick(); redirect_valid = 1'b0;
        repeat (8) tick();
        check("s5_wrap_addr0", acc_addr[0], 32'hFFFF_FFF8);
        check("s5_wrap_addr1", acc_addr[1], 32'hFFFF_FFFC);
        check("s5_wrap_addr2", acc_addr[2], 32'h0000_0000);
        check("s5_stream_active", {31'b0, id_valid}, 32'd1);

        // Asynchronous reset in the middle of the live stream.
        do_reset(1, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
